// File: rtl/dcache_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_bridge_pkg
// Description : Shared widths, FSM state encoding and address helper for the
//               data-cache bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Clears the byte offset so memory always sees word addresses.
  localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & WORD_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_bridge_if
// Description : CPU request/response and memory read/write channels of the
//               data-cache bridge. The master modport is the CPU plus memory
//               environment; the slave modport is the bridge itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_bridge_if;
  import dcache_bridge_pkg::*;

  // CPU side
  logic              valid;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] write_type;
  logic [DATA_W-1:0] w_data_CPU;
  logic              addr_valid;
  logic              data_valid;
  logic [DATA_W-1:0] r_data_CPU;

  // Memory read channel
  logic              mem_rd_req;
  logic              mem_rd_rdy;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_ret_valid;
  logic [DATA_W-1:0] mem_ret_data;

  // Memory write channel
  logic              mem_wr_req;
  logic              mem_wr_rdy;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [STRB_W-1:0] mem_wr_strb;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output valid, op, addr, write_type, w_data_CPU,
    input  addr_valid, data_valid, r_data_CPU,
    output mem_rd_rdy, mem_ret_valid, mem_ret_data, mem_wr_rdy,
    input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_strb, mem_wr_data
  );

  modport slave (
    input  valid, op, addr, write_type, w_data_CPU,
    output addr_valid, data_valid, r_data_CPU,
    input  mem_rd_rdy, mem_ret_valid, mem_ret_data, mem_wr_rdy,
    output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_strb, mem_wr_data
  );

endinterface
`default_nettype wire

// File: rtl/dcache_bridge_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : dcache_bridge_wbuf
// Description : One-entry posted write buffer. Holds a store until the memory
//               write handshake completes; can drain and refill in one cycle.
//               Used only when DCACHE_BRIDGE_WBUF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_bridge_wbuf
  import dcache_bridge_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic [ADDR_W-1:0] push_addr,
  input  wire logic [STRB_W-1:0] push_strb,
  input  wire logic [DATA_W-1:0] push_data,
  input  wire logic              wr_rdy,
  output logic                   wr_req,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [STRB_W-1:0]      wr_strb,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   can_push,
  output logic                   empty
);

  logic full;
  logic pop;

  assign pop      = full && wr_rdy;
  assign can_push = !full || wr_rdy;
  assign empty    = !full;
  assign wr_req   = full;

  // Occupancy: a push wins over a simultaneous pop so drain+refill stays full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Entry payload, loaded on push and held stable while the request is up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      wr_strb <= '0;
      wr_data <= '0;
    end else if (push) begin
      wr_addr <= word_align(push_addr);
      wr_strb <= push_strb;
      wr_data <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dcache_bridge
// Description : Bridges single CPU load/store requests onto a split memory
//               read/write handshake bus. One request in flight at a time.
//               Optional macro DCACHE_BRIDGE_WBUF_EN adds a one-entry posted
//               write buffer (sub-module dcache_bridge_wbuf).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_bridge
  import dcache_bridge_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst,
  dcache_bridge_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              addr_ok;
  logic              store_mem;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] rd_data;

  // A store that actually touches memory (all-zero byte enables do not).
  assign store_mem = bus.op && (bus.write_type != '0);
  assign accept    = bus.valid && addr_ok;

`ifdef DCACHE_BRIDGE_WBUF_EN
  logic wb_can_push;
  logic wb_empty;

  dcache_bridge_wbuf u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && store_mem),
    .push_addr (bus.addr),
    .push_strb (bus.write_type),
    .push_data (bus.w_data_CPU),
    .wr_rdy    (bus.mem_wr_rdy),
    .wr_req    (bus.mem_wr_req),
    .wr_addr   (bus.mem_wr_addr),
    .wr_strb   (bus.mem_wr_strb),
    .wr_data   (bus.mem_wr_data),
    .can_push  (wb_can_push),
    .empty     (wb_empty)
  );

  // Accept only in IDLE; stores need buffer room, loads need it drained.
  always_comb begin
    addr_ok = 1'b0;
    if (state == IDLE) begin
      addr_ok = bus.op ? wb_can_push : wb_empty;
    end
  end
`else
  logic [STRB_W-1:0] req_strb;
  logic [DATA_W-1:0] req_data;

  // Store payload held for the duration of WR_REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_strb <= '0;
      req_data <= '0;
    end else if (accept) begin
      req_strb <= bus.write_type;
      req_data <= bus.w_data_CPU;
    end
  end

  // Without a buffer the bridge accepts whenever it is idle.
  always_comb begin
    addr_ok = (state == IDLE);
  end

  assign bus.mem_wr_req  = (state == WR_REQ);
  assign bus.mem_wr_addr = req_addr;
  assign bus.mem_wr_strb = req_strb;
  assign bus.mem_wr_data = req_data;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; inputs that do not matter in a state are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!bus.op) begin
            state_nxt = RD_REQ;
          end else if (!store_mem) begin
            state_nxt = RESP;
          end else begin
`ifdef DCACHE_BRIDGE_WBUF_EN
            state_nxt = RESP;
`else
            state_nxt = WR_REQ;
`endif
          end
        end
      end
      RD_REQ:  if (bus.mem_rd_rdy)    state_nxt = RD_WAIT;
      RD_WAIT: if (bus.mem_ret_valid) state_nxt = RESP;
      WR_REQ:  if (bus.mem_wr_rdy)    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word-aligned request address, frozen from accept until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= '0;
    end else if (accept) begin
      req_addr <= word_align(bus.addr);
    end
  end

  // Read return capture; holds the last word between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if ((state == RD_WAIT) && bus.mem_ret_valid) begin
      rd_data <= bus.mem_ret_data;
    end
  end

  assign bus.addr_valid  = addr_ok;
  assign bus.data_valid  = (state == RESP);
  assign bus.r_data_CPU  = rd_data;
  assign bus.mem_rd_req  = (state == RD_REQ);
  assign bus.mem_rd_addr = req_addr;

endmodule
`default_nettype wire

// File: tb/tb_dcache_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_bridge
// Description : Directed self-checking bench for dcache_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_bridge;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  dcache_bridge_if bus ();

  dcache_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid         = 1'b0;
    bus.op            = 1'b0;
    bus.addr          = '0;
    bus.write_type    = '0;
    bus.w_data_CPU    = '0;
    bus.mem_rd_rdy    = 1'b0;
    bus.mem_ret_valid = 1'b0;
    bus.mem_ret_data  = '0;
    bus.mem_wr_rdy    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b want 0", bus.data_valid); end
    checks++; if (bus.mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req: got %b want 0", bus.mem_rd_req); end
    checks++; if (bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL rst_wr_req: got %b want 0", bus.mem_wr_req); end
    checks++; if (bus.r_data_CPU !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.r_data_CPU); end
    checks++; if (bus.mem_rd_addr !== 32'h0) begin errors++; $display("FAIL rst_rd_addr: got %h want 0", bus.mem_rd_addr); end
    checks++; if (bus.mem_wr_addr !== 32'h0) begin errors++; $display("FAIL rst_wr_addr: got %h want 0", bus.mem_wr_addr); end
    checks++; if (bus.mem_wr_strb !== 4'h0) begin errors++; $display("FAIL rst_wr_strb: got %h want 0", bus.mem_wr_strb); end
    checks++; if (bus.mem_wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", bus.mem_wr_data); end
    rst = 1'b0;
    tick();
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL rst_addr_valid: got %b want 1", bus.addr_valid); end
  endtask

  // Minimum-latency read with a stray return pulse during RD_REQ.
  task automatic test_read();
    bus.valid = 1'b1; bus.op = 1'b0; bus.addr = 32'h1C00_0006;
    #1;
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL rd_accept: got %b want 1", bus.addr_valid); end
    tick(); // T+1
    bus.valid = 1'b0;
    checks++; if (bus.mem_rd_req !== 1'b1) begin errors++; $display("FAIL rd_req: got %b want 1", bus.mem_rd_req); end
    checks++; if (bus.mem_rd_addr !== 32'h1C00_0004) begin errors++; $display("FAIL rd_addr: got %h want 1c000004", bus.mem_rd_addr); end
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL rd_busy_av: got %b want 0", bus.addr_valid); end
    bus.mem_rd_rdy = 1'b1; bus.mem_ret_valid = 1'b1; bus.mem_ret_data = 32'h0000_0BAD;
    tick(); // T+2
    bus.mem_rd_rdy = 1'b0;
    checks++; if (bus.mem_rd_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b want 0", bus.mem_rd_req); end
    bus.mem_ret_valid = 1'b1; bus.mem_ret_data = 32'hDEAD_BEEF;
    tick(); // T+3
    bus.mem_ret_valid = 1'b0; bus.mem_ret_data = 32'h0;
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL rd_dv: got %b want 1", bus.data_valid); end
    checks++; if (bus.r_data_CPU !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", bus.r_data_CPU); end
    tick(); // T+4
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rd_dv_end: got %b want 0", bus.data_valid); end
    checks++; if (bus.r_data_CPU !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_hold: got %h want deadbeef", bus.r_data_CPU); end
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL rd_idle_av: got %b want 1", bus.addr_valid); end
  endtask

  task automatic test_write_delayed();
    bus.valid = 1'b1; bus.op = 1'b1; bus.addr = 32'h0000_0100;
    bus.write_type = 4'b0011; bus.w_data_CPU = 32'h1234_ABCD;
    tick(); // T+1
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.mem_wr_req !== 1'b1) begin errors++; $display("FAIL wr_req_hold%0d: got %b want 1", i, bus.mem_wr_req); end
      checks++; if (bus.mem_wr_addr !== 32'h100) begin errors++; $display("FAIL wr_addr%0d: got %h want 100", i, bus.mem_wr_addr); end
      checks++; if (bus.mem_wr_strb !== 4'b0011) begin errors++; $display("FAIL wr_strb%0d: got %h want 3", i, bus.mem_wr_strb); end
      checks++; if (bus.mem_wr_data !== 32'h1234_ABCD) begin errors++; $display("FAIL wr_data%0d: got %h want 1234abcd", i, bus.mem_wr_data); end
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL wr_early_dv%0d: got %b want 0", i, bus.data_valid); end
      tick();
    end
    bus.mem_wr_rdy = 1'b1;
    checks++; if (bus.mem_wr_req !== 1'b1) begin errors++; $display("FAIL wr_req_hs: got %b want 1", bus.mem_wr_req); end
    tick();
    bus.mem_wr_rdy = 1'b0;
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL wr_dv: got %b want 1", bus.data_valid); end
    checks++; if (bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL wr_req_end: got %b want 0", bus.mem_wr_req); end
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL wr_dv_single: got %b want 0", bus.data_valid); end
  endtask

  task automatic test_write_zero_strb();
    bus.valid = 1'b1; bus.op = 1'b1; bus.addr = 32'h0000_0200;
    bus.write_type = 4'b0000; bus.w_data_CPU = 32'hFFFF_FFFF;
    tick(); // T+1
    drive_idle();
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL wz_dv: got %b want 1", bus.data_valid); end
    checks++; if (bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL wz_wr_req: got %b want 0", bus.mem_wr_req); end
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL wz_dv_end: got %b want 0", bus.data_valid); end
    checks++; if (bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL wz_wr_req2: got %b want 0", bus.mem_wr_req); end
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL wz_av: got %b want 1", bus.addr_valid); end
  endtask

  task automatic test_reset_mid_read();
    bus.valid = 1'b1; bus.op = 1'b0; bus.addr = 32'h0000_0040;
    tick(); // T+1
    bus.valid = 1'b0; bus.mem_rd_rdy = 1'b1;
    tick(); // T+2, RD_WAIT
    bus.mem_rd_rdy = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL mr_dv: got %b want 0", bus.data_valid); end
    checks++; if (bus.mem_rd_req !== 1'b0) begin errors++; $display("FAIL mr_rd_req: got %b want 0", bus.mem_rd_req); end
    checks++; if (bus.r_data_CPU !== 32'h0) begin errors++; $display("FAIL mr_rdata: got %h want 0", bus.r_data_CPU); end
    checks++; if (bus.mem_rd_addr !== 32'h0) begin errors++; $display("FAIL mr_rd_addr: got %h want 0", bus.mem_rd_addr); end
    tick();
    rst = 1'b0;
    bus.mem_ret_valid = 1'b1; bus.mem_ret_data = 32'h5555_5555;
    tick();
    bus.mem_ret_valid = 1'b0; bus.mem_ret_data = 32'h0;
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL mr_no_dv: got %b want 0", bus.data_valid); end
    checks++; if (bus.r_data_CPU !== 32'h0) begin errors++; $display("FAIL mr_rdata2: got %h want 0", bus.r_data_CPU); end
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL mr_idle: got %b want 1", bus.addr_valid); end
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL mr_no_dv2: got %b want 0", bus.data_valid); end
  endtask

  // valid held high: second read is taken the cycle after data_valid.
  task automatic test_back_to_back();
    bus.mem_rd_rdy = 1'b1; bus.mem_ret_valid = 1'b1;
    bus.valid = 1'b1; bus.op = 1'b0; bus.addr = 32'h0000_1008;
    bus.mem_ret_data = 32'hAAAA_0001;
    tick(); // T+1
    checks++; if (bus.mem_rd_addr !== 32'h0000_1008) begin errors++; $display("FAIL b2b_addr1: got %h want 1008", bus.mem_rd_addr); end
    tick(); // T+2
    tick(); // T+3
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL b2b_dv1: got %b want 1", bus.data_valid); end
    checks++; if (bus.r_data_CPU !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_data1: got %h want aaaa0001", bus.r_data_CPU); end
    bus.addr = 32'h0000_200F; bus.mem_ret_data = 32'hBBBB_0002;
    tick(); // T+4, IDLE again
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", bus.data_valid); end
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL b2b_av: got %b want 1", bus.addr_valid); end
    tick(); // T+5
    checks++; if (bus.mem_rd_req !== 1'b1) begin errors++; $display("FAIL b2b_req2: got %b want 1", bus.mem_rd_req); end
    checks++; if (bus.mem_rd_addr !== 32'h0000_200C) begin errors++; $display("FAIL b2b_addr2: got %h want 200c", bus.mem_rd_addr); end
    tick(); // T+6
    tick(); // T+7
    bus.valid = 1'b0;
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL b2b_dv2: got %b want 1", bus.data_valid); end
    checks++; if (bus.r_data_CPU !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_data2: got %h want bbbb0002", bus.r_data_CPU); end
    drive_idle();
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", bus.data_valid); end
  endtask

`ifdef DCACHE_BRIDGE_WBUF_EN
  task automatic test_wbuf();
    bus.valid = 1'b1; bus.op = 1'b1; bus.addr = 32'h0000_0300;
    bus.write_type = 4'hF; bus.w_data_CPU = 32'h1111_1111;
    #1;
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL wb_accept1: got %b want 1", bus.addr_valid); end
    tick(); // T+1
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL wb_dv1: got %b want 1", bus.data_valid); end
    checks++; if (bus.mem_wr_req !== 1'b1) begin errors++; $display("FAIL wb_req1: got %b want 1", bus.mem_wr_req); end
    checks++; if (bus.mem_wr_addr !== 32'h300) begin errors++; $display("FAIL wb_addr1: got %h want 300", bus.mem_wr_addr); end
    bus.addr = 32'h0000_0304; bus.w_data_CPU = 32'h2222_2222;
    tick(); // T+2
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL wb_stall%0d: got %b want 0", i, bus.addr_valid); end
      tick();
    end
    bus.mem_wr_rdy = 1'b1; // T+6: drain and refill together
    #1;
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL wb_refill_av: got %b want 1", bus.addr_valid); end
    tick(); // T+7
    bus.mem_wr_rdy = 1'b0;
    checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL wb_dv2: got %b want 1", bus.data_valid); end
    checks++; if (bus.mem_wr_addr !== 32'h304) begin errors++; $display("FAIL wb_addr2: got %h want 304", bus.mem_wr_addr); end
    checks++; if (bus.mem_wr_data !== 32'h2222_2222) begin errors++; $display("FAIL wb_data2: got %h want 22222222", bus.mem_wr_data); end
    bus.op = 1'b0; bus.addr = 32'h0000_0400; bus.write_type = 4'h0;
    tick(); // T+8
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL wb_rd_block: got %b want 0", bus.addr_valid); end
    bus.mem_wr_rdy = 1'b1;
    #1;
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL wb_rd_nofwd: got %b want 0", bus.addr_valid); end
    tick(); // T+9
    bus.mem_wr_rdy = 1'b0;
    checks++; if (bus.mem_wr_req !== 1'b0) begin errors++; $display("FAIL wb_drained: got %b want 0", bus.mem_wr_req); end
    checks++; if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL wb_rd_accept: got %b want 1", bus.addr_valid); end
    tick(); // T+10
    bus.valid = 1'b0;
    checks++; if (bus.mem_rd_req !== 1'b1) begin errors++; $display("FAIL wb_rd_req: got %b want 1", bus.mem_rd_req); end
    bus.mem_rd_rdy = 1'b1;
    tick();
    bus.mem_rd_rdy = 1'b0; bus.mem_ret_valid = 1'b1; bus.mem_ret_data = 32'h0404_0404;
    tick();
    drive_idle();
    checks++; if (bus.r_data_CPU !== 32'h0404_0404) begin errors++; $display("FAIL wb_rd_data: got %h want 04040404", bus.r_data_CPU); end
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
`ifdef DCACHE_BRIDGE_WBUF_EN
    test_wbuf();
`else
    test_write_delayed();
`endif
    test_write_zero_strb();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_bridge.md
DCACHE_BRIDGE -- requirements
Module: dcache_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports listed clock and reset first:
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 valid  in  1  CPU request; held by CPU until accepted.
REQ-005 op  in  1  1 = write, 0 = read.
REQ-006 addr  in  32  CPU byte address.
REQ-007 write_type  in  4  byte write enable.
REQ-008 w_data_CPU  in  32  store data.
REQ-009 addr_valid  out  1  combinational accept; request taken when valid&&addr_valid.
REQ-010 data_valid  out  1  registered one-cycle completion pulse: read data returned or write done.
REQ-011 r_data_CPU  out  32  raw read word, valid while data_valid=1.
REQ-012 mem_rd_req/mem_rd_rdy  out/in  1/1  read-address handshake.
REQ-013 mem_rd_addr  out  32  word-aligned read address {addr[31:2],2'b00}.
REQ-014 mem_ret_valid/mem_ret_data  in/in  1/32  read return, single beat.
REQ-015 mem_wr_req/mem_wr_rdy  out/in  1/1  write handshake; write complete on req&&rdy.
REQ-016 mem_wr_addr, mem_wr_strb, mem_wr_data  out  32/4/32  word-aligned address, byte strobe, data.

Function
REQ-017 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
REQ-018 addr_valid SHALL be 1 only in IDLE, and only with no write-buffer entry pending for reads (REQ-030).
REQ-019 On accept, addr/op/write_type/w_data_CPU SHALL be latched; read -> RD_REQ, write with write_type!=0 -> WR_REQ, write with write_type==0 -> RESP (no memory write).
REQ-020 RD_REQ: mem_rd_req held 1 until mem_rd_rdy, then -> RD_WAIT; address SHALL not change while req held.
REQ-021 RD_WAIT: on mem_ret_valid, mem_ret_data SHALL be latched into r_data_CPU and state -> RESP.
REQ-022 WR_REQ: mem_wr_req held 1 until mem_wr_rdy, then -> RESP.
REQ-023 RESP: data_valid=1 for exactly that cycle, then -> IDLE; minimum read latency accept T -> data_valid T+3 (rdy at T+1, ret at T+2).
REQ-024 mem_ret_valid outside RD_WAIT SHALL be ignored; valid outside IDLE SHALL be ignored.
REQ-025 r_data_CPU SHALL hold its last value when data_valid=0.
REQ-026 Back-to-back: accept in the cycle RESP returns to IDLE is permitted (next cycle after data_valid).

Reset
REQ-027 On rst: state IDLE; data_valid, mem_rd_req, mem_wr_req 0; r_data_CPU, mem_* address/data/strb 0; write buffer empty.
REQ-028 Reset mid-transaction SHALL abandon it; no data_valid issued after rst deasserts for the abandoned request.

Configuration
REQ-029 Macro DCACHE_BRIDGE_WBUF_EN defined: one-entry write buffer; accepted store with write_type!=0 goes to buffer, FSM -> RESP (data_valid at T+1); buffer drains via mem_wr_* independently of FSM.
REQ-030 With DCACHE_BRIDGE_WBUF_EN: store while buffer full SHALL not be accepted (addr_valid=0); read SHALL not be accepted until buffer empty (no forwarding); buffer may drain and refill in one cycle.
REQ-031 Macro undefined: no buffer; stores use WR_REQ per REQ-022; behaviour otherwise identical.

Structure
REQ-032 FSM state encodings and width constants SHALL live in a shared header included like the uop header.
REQ-033 The write buffer SHALL be sub-module dcache_bridge_wbuf, instantiated only under DCACHE_BRIDGE_WBUF_EN.

Verification
REQ-034 Read addr=0x1C000006, rdy immediate, ret 0xDEADBEEF next cycle -> mem_rd_addr=0x1C000004, data_valid at T+3, r_data_CPU=0xDEADBEEF.
REQ-035 Write addr=0x100, strb=4'b0011, data=0x1234ABCD, mem_wr_rdy delayed 3 cycles -> mem_wr_req held stable 3 cycles, single data_valid after handshake.
REQ-036 Write with write_type=0 -> no mem_wr_req, data_valid at T+1.
REQ-037 rst asserted in RD_WAIT, then mem_ret_valid -> no data_valid, state IDLE, outputs 0.
REQ-038 WBUF_EN: two stores then read, mem_wr_rdy low 5 cycles -> first data_valid T+1, second store stalled (addr_valid=0) until drain, read accepted only after buffer empty.
